// File: rtl/product_uart_rx_if.sv
// Signal bundle between the serial line and the product receiver.
// The slave side is the receiver: it takes rx in and drives the rebuilt byte
// and its strobes. The master side drives the line and observes the results.
interface product_uart_rx_if;
  logic       rx;
  logic [7:0] product;
  logic       product_valid;
  logic       frame_err;
  logic       busy;

  modport master (output rx, input product, product_valid, frame_err, busy);
  modport slave  (input rx, output product, product_valid, frame_err, busy);
endinterface

// File: rtl/product_uart_rx.sv
// 8N1 serial receiver that rebuilds the booth_multiplier signed product.
// The line is double-flopped, the start bit is confirmed at its centre, and
// each data and stop bit is sampled one full bit-time after the previous
// sample. IDLE is re-entered at mid-stop-bit, so back-to-back frames need no gap.
// A stop bit sampled low parks the receiver in BREAK until the line returns
// high, so a line held low cannot retrigger frames.
// CLKS_PER_BIT must be even, must be at least 4, and must match the transmitter.
module product_uart_rx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  product_uart_rx_if.slave bus
);

  localparam int               CNT_W     = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shreg_q, shreg_d;
  logic [7:0]       product_q, product_d;
  logic             product_valid_q, product_valid_d;
  logic             frame_err_q, frame_err_d;
  logic             rx_meta_q, rx_s_q;

  // Two-flop synchronizer for the asynchronous line; it resets to the idle-high level.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= bus.rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  // State, counters, shift register and the registered output strobes.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q         <= ST_IDLE;
      cnt_q           <= '0;
      bit_idx_q       <= '0;
      shreg_q         <= '0;
      product_q       <= '0;
      product_valid_q <= 1'b0;
      frame_err_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      bit_idx_q       <= bit_idx_d;
      shreg_q         <= shreg_d;
      product_q       <= product_d;
      product_valid_q <= product_valid_d;
      frame_err_q     <= frame_err_d;
    end
  end

  // Next-state logic: confirm the start bit at half a bit-time, then sample at every full bit-time.
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    bit_idx_d       = bit_idx_q;
    shreg_d         = shreg_q;
    product_d       = product_q;
    product_valid_d = 1'b0;
    frame_err_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!rx_s_q) begin
          state_d = ST_START;
          cnt_d   = '0;
        end
      end

      ST_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          if (!rx_s_q) begin
            state_d   = ST_DATA;
            bit_idx_d = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_DATA: begin
        if (cnt_q == FULL_LAST) begin
          cnt_d   = '0;
          shreg_d = {rx_s_q, shreg_q[7:1]};
          if (bit_idx_q == 3'd7) begin
            state_d = ST_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_STOP: begin
        if (cnt_q == FULL_LAST) begin
          cnt_d = '0;
          if (rx_s_q) begin
            product_d       = shreg_q;
            product_valid_d = 1'b1;
            state_d         = ST_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = ST_BREAK;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_BREAK: begin
        if (rx_s_q) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.product       = product_q;
  assign bus.product_valid = product_valid_q;
  assign bus.frame_err     = frame_err_q;
  assign bus.busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_product_uart_rx.sv
// Directed and randomized bench for product_uart_rx.
// A reference model tracks the last good byte and the expected strobe counts;
// a monitor timestamps strobes and flags protocol violations.
module tb_product_uart_rx;

  localparam int CLKS = 16;

  logic CLK;
  logic RST_N;

  product_uart_rx_if bus ();

  product_uart_rx #(.CLKS_PER_BIT(CLKS)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  // Free-running clock with a 10-time-unit period.
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks;
  int errors;
  int cycle;
  int valid_cnt;
  int err_cnt;
  int last_valid_cycle;
  int pulse_viol;
  int start_cycle;
  logic       prev_valid;
  logic       prev_err;
  logic [7:0] prev_product;

  logic [7:0] exp_product;
  int         exp_valid;
  int         exp_err;

  // Cycle counter used to timestamp events.
  always @(posedge CLK) cycle++;

  // Strobe monitor: count pulses and record one-cycle, exclusivity and product-hold violations.
  always @(negedge CLK) begin
    if (bus.product_valid === 1'b1) begin
      valid_cnt++;
      last_valid_cycle = cycle;
    end
    if (bus.frame_err === 1'b1) err_cnt++;
    if (bus.product_valid === 1'b1 && bus.frame_err === 1'b1) pulse_viol++;
    if (bus.product_valid === 1'b1 && prev_valid === 1'b1) pulse_viol++;
    if (bus.frame_err === 1'b1 && prev_err === 1'b1) pulse_viol++;
    if (RST_N === 1'b1 && bus.product_valid !== 1'b1 && bus.product !== prev_product) pulse_viol++;
    prev_valid   = bus.product_valid;
    prev_err     = bus.frame_err;
    prev_product = bus.product;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Drive one 8N1 frame starting on a falling clock edge; abort_bit >= 0 stops mid-way through that bit slot.
  task automatic applyStimulus(input logic [7:0] data, input logic stop_bit, input int abort_bit);
    logic [9:0] frame;
    frame = {stop_bit, data, 1'b0};
    start_cycle = cycle;
    for (int i = 0; i < 10; i++) begin
      bus.rx = frame[i];
      if (i == abort_bit) begin
        repeat (CLKS / 2) @(negedge CLK);
        return;
      end
      repeat (CLKS) @(negedge CLK);
    end
  endtask

  task automatic checkModel(input string tag);
    checkOutput({tag, "_product"}, {24'd0, bus.product}, {24'd0, exp_product});
    checkOutput({tag, "_valid_cnt"}, valid_cnt, exp_valid);
    checkOutput({tag, "_err_cnt"}, err_cnt, exp_err);
  endtask

  initial begin
    int v1;
    int lat;
    int gap;
    logic [7:0] d;
    logic       s;

    checks = 0; errors = 0; cycle = 0;
    valid_cnt = 0; err_cnt = 0; last_valid_cycle = 0; pulse_viol = 0;
    prev_valid = 1'b0; prev_err = 1'b0; prev_product = 8'h00;
    exp_product = 8'h00; exp_valid = 0; exp_err = 0;

    // Reset state
    RST_N  = 1'b0;
    bus.rx = 1'b1;
    repeat (3) @(negedge CLK);
    checkOutput("reset_product", {24'd0, bus.product}, 32'h00);
    checkOutput("reset_valid", {31'd0, bus.product_valid}, 32'd0);
    checkOutput("reset_err", {31'd0, bus.frame_err}, 32'd0);
    checkOutput("reset_busy", {31'd0, bus.busy}, 32'd0);
    RST_N = 1'b1;
    repeat (CLKS) @(negedge CLK);

    // 7 x -2 = -14
    applyStimulus(8'hF2, 1'b1, -1);
    exp_product = 8'hF2; exp_valid++;
    repeat (CLKS) @(negedge CLK);
    checkModel("f2");
    checkOutput("f2_busy_idle", {31'd0, bus.busy}, 32'd0);
    lat = last_valid_cycle - start_cycle;
    $display("[TB] start-to-valid latency %0d cycles", lat);
    checkOutput("latency_154pm1", {31'd0, (lat >= 153 && lat <= 155)}, 32'd1);

    // False start
    bus.rx = 1'b0;
    repeat (5) @(negedge CLK);
    checkOutput("glitch_busy_high", {31'd0, bus.busy}, 32'd1);
    bus.rx = 1'b1;
    repeat (2 * CLKS) @(negedge CLK);
    checkOutput("glitch_busy_idle", {31'd0, bus.busy}, 32'd0);
    checkModel("glitch");

    // -1 x 2 = -2, then 0, back-to-back
    applyStimulus(8'hFE, 1'b1, -1);
    exp_product = 8'hFE; exp_valid++;
    checkModel("b2b_fe");
    v1 = last_valid_cycle;
    applyStimulus(8'h00, 1'b1, -1);
    exp_product = 8'h00; exp_valid++;
    checkModel("b2b_00");
    checkOutput("b2b_spacing", {31'd0, ((last_valid_cycle - v1) >= 159 && (last_valid_cycle - v1) <= 161)}, 32'd1);
    repeat (CLKS) @(negedge CLK);

    // Bad stop bit followed by a held-low line
    applyStimulus(8'h5A, 1'b0, -1);
    exp_err++;
    repeat (40) @(negedge CLK);
    checkModel("badstop");
    checkOutput("badstop_busy_held", {31'd0, bus.busy}, 32'd1);
    bus.rx = 1'b1;
    repeat (4) @(negedge CLK);
    checkOutput("badstop_busy_release", {31'd0, bus.busy}, 32'd0);
    repeat (CLKS) @(negedge CLK);
    applyStimulus(8'h3C, 1'b1, -1);
    exp_product = 8'h3C; exp_valid++;
    checkModel("after_break");

    // Reset during data bit 4
    applyStimulus(8'h96, 1'b1, 5);
    checkOutput("midframe_busy", {31'd0, bus.busy}, 32'd1);
    RST_N = 1'b0;
    #1;
    checkOutput("midreset_product", {24'd0, bus.product}, 32'h00);
    checkOutput("midreset_valid", {31'd0, bus.product_valid}, 32'd0);
    checkOutput("midreset_err", {31'd0, bus.frame_err}, 32'd0);
    checkOutput("midreset_busy", {31'd0, bus.busy}, 32'd0);
    bus.rx = 1'b1;
    exp_product = 8'h00;
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    repeat (CLKS + 2) @(negedge CLK);
    checkModel("post_reset");
    applyStimulus(8'hA5, 1'b1, -1);
    exp_product = 8'hA5; exp_valid++;
    checkModel("a5");

    // Randomized frames with random stop bits and gaps
    for (int n = 0; n < 8; n++) begin
      d   = 8'($urandom_range(0, 255));
      s   = ($urandom_range(0, 3) != 0);
      gap = $urandom_range(0, 20);
      if (!s) gap += CLKS;
      applyStimulus(d, s, -1);
      if (s) begin
        exp_product = d;
        exp_valid++;
      end else begin
        exp_err++;
      end
      bus.rx = 1'b1;
      repeat (gap) @(negedge CLK);
      checkModel($sformatf("rand%0d", n));
    end

    repeat (2 * CLKS) @(negedge CLK);
    checkOutput("final_busy", {31'd0, bus.busy}, 32'd0);
    checkOutput("strobe_rules", pulse_viol, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/product_uart_rx.md
Name: product_uart_rx

Overview:
- Serial receiver downstream of booth_multiplier; consumes its `tx` line and rebuilds the 8-bit signed product as a parallel byte for checking and logging.
- Line format is 8N1: start bit (0), 8 data bits LSB first, one stop bit (1). Line idles high.
- Raises a one-cycle valid strobe per good frame and a one-cycle error strobe per bad stop bit.

Parameters:
- CLKS_PER_BIT, 16, CLK cycles per serial bit; must be even and >= 4; must match the transmitter.

Ports:
- CLK  input  1  system clock, rising edge.
- RST_N  input  1  asynchronous active-low reset.
- rx  input  1  serial line, connected to booth_multiplier `tx`; asynchronous to the frame.
- product  output  8  last correctly received byte (two's-complement product).
- product_valid  output  1  one-cycle pulse; product updated this cycle.
- frame_err  output  1  one-cycle pulse; stop bit sampled low.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (async assert, sync release) forces state=IDLE, product=8'h00, product_valid=0, frame_err=0, busy=0, and synchronizer flops=1.
- Synchronizer: rx passes through a 2-flop synchronizer to give rx_s. All decisions use rx_s only.
- Counters: cnt is the bit-time counter, sized for CLKS_PER_BIT-1. bit_idx is 3 bits. shreg is the 8-bit shift register.
- IDLE:
  - If rx_s==0, go to START with cnt=0.
  - Otherwise stay.
- START:
  - cnt increments each cycle.
  - At cnt==CLKS_PER_BIT/2-1, sample rx_s.
  - If rx_s==0, go to DATA with cnt=0 and bit_idx=0.
  - If rx_s==1 (glitch or false start), go to IDLE with no strobe.
- DATA:
  - At cnt==CLKS_PER_BIT-1, do shreg <= {rx_s, shreg[7:1]} and set cnt=0.
  - If bit_idx==7, go to STOP; otherwise bit_idx++.
  - Each sample lands at the centre of its bit.
- STOP:
  - At cnt==CLKS_PER_BIT-1, sample rx_s.
  - If rx_s==1: product<=shreg and product_valid=1 for exactly that one registered cycle, then go to IDLE.
  - If rx_s==0: frame_err=1 for one cycle, product unchanged, go to BREAK.
- BREAK: stay until rx_s==1, then go to IDLE. This prevents a held-low line from retriggering frames.
- Strobes: product_valid and frame_err are registered, mutually exclusive, and never high for more than one cycle.
- Back-to-back frames:
  - IDLE is re-entered at mid-stop-bit, so a start edge arriving immediately after the stop bit is caught.
  - No idle gap is required.
- Latency: from the rx falling edge of a start bit to product_valid is 2 (synchronizer) + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT cycles, ±1 cycle for edge phase. This is 154 ±1 at the default.
- Reset mid-frame: the frame is abandoned with no strobe. After release the block waits in IDLE; it resyncs on the next falling edge. Bits of an interrupted frame may produce a frame_err, which is acceptable.
- product is held between frames. It changes only together with product_valid.

Test Plan:
- Multiplier 7 × multiplicand -2 (4'b0111, 4'b1110). Send the serial frame of 8'hF2 at CLKS_PER_BIT=16 -> a single product_valid pulse, product==8'hF2 (-14), frame_err never high, busy returns to 0.
- -1 × 2 (4'b1111, 4'b0010). Send frame 8'hFE, then frame 8'h00 back-to-back with no idle gap -> two valid pulses, product 8'hFE then 8'h00, exactly 10*16 ±1 cycles apart.
- Glitch: rx low for 5 cycles then high -> START aborts at the mid-bit check, no strobes, state returns to IDLE, product keeps its prior value.
- Bad stop: send 8'h5A with the stop bit driven 0 and the line held low for 40 more cycles -> one frame_err pulse, no product_valid, product unchanged. busy stays high until rx returns high, then a following 8'h3C frame is received correctly.
- Reset mid-frame: assert RST_N low during data bit 4 of a frame -> all outputs 0 immediately (asynchronous). After release plus a full idle-high bit, the next 8'hA5 frame yields product==8'hA5.
- Latency check: measure from the start-bit falling edge to product_valid -> 154 ±1 cycles at CLKS_PER_BIT=16.
